mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 38 +++
 rtl/mem_lane_fmt.sv | 32 +++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the MIPS core memory path: instruction opcodes,
// ALU operation codes, the memory arbiter FSM encodings and its parameter
// defaults, plus a small byte-lane helper.
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    // MIPS primary opcodes used by the decoder
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // ALU operation select
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;

    // Memory arbiter defaults
    localparam int MEM_LAT_DEF    = 1;
    localparam int STARVE_MAX_DEF = 3;

    // Memory arbiter FSM encodings
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY_IF = 2'd1;
    localparam logic [1:0] ST_BUSY_DM = 2'd2;

    // One-hot byte lane for a byte offset within a word (offset 0 -> bit 0)
    function automatic logic [3:0] byte_onehot(input logic [1:0] offs);
        return 4'b0001 << offs;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// ---------------------------------------------------------------------------
// mem_lane_fmt
// Formats store data for the memory: byte stores are replicated on all four
// lanes with a single byte enable, word stores pass through with all lanes.
// Ports:
//   dm_byte   in   1   sub-word (byte) store
//   dm_addr   in   2   byte offset within the word
//   dm_wdata  in  32   store data from the data port
//   mem_be    out  4   byte enables
//   mem_wdata out 32   formatted write data
// ---------------------------------------------------------------------------
module mem_lane_fmt
    import mem_arbiter_pkg::*;
(
    input  logic        dm_byte,
    input  logic [1:0]  dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata
);

    always_comb begin
        if (dm_byte) begin
            mem_be    = byte_onehot(dm_addr);
            mem_wdata = {4{dm_wdata[7:0]}};
        end else begin
            mem_be    = 4'b1111;
            mem_wdata = dm_wdata;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Arbitrates a fetch port and a data port onto a single fixed-latency memory.
// One transaction may be outstanding. The data port wins ties unless the
// fetch port has been passed over STARVE_MAX times in a row.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   if_req/if_addr        fetch request and word address
//   if_gnt/if_valid       fetch accepted / fetch data pulse
//   if_rdata              fetch data (meaningful with if_valid)
//   dm_req/dm_we/dm_byte  data request, store, byte-store qualifiers
//   dm_addr/dm_wdata      data address and store data
//   dm_gnt/dm_valid       data accepted / completion pulse
//   dm_rdata              raw aligned load word (meaningful with dm_valid)
//   mem_en/mem_we         memory strobe and write enable
//   mem_addr/mem_be       word address and byte enables
//   mem_wdata/mem_rdata   memory write and read data
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic        dm_byte,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_valid,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]  r_state;
    logic [3:0]  r_starve_cnt;
    logic [2:0]  r_lat_cnt;
    logic [31:0] r_if_rdata;
    logic [31:0] r_dm_rdata;

    logic        w_idle;
    logic        w_if_prio;
    logic        w_dm_win;
    logic        w_if_win;
    logic        w_last;
    logic [3:0]  w_fmt_be;
    logic [31:0] w_fmt_wdata;
    logic [31:0] w_sel_addr;

    mem_lane_fmt u_lane_fmt (
        .dm_byte   (dm_byte),
        .dm_addr   (dm_addr[1:0]),
        .dm_wdata  (dm_wdata),
        .mem_be    (w_fmt_be),
        .mem_wdata (w_fmt_wdata)
    );

    // Grants are combinational from IDLE; rst gates them so nothing is
    // granted while the block is held in reset.
    assign w_idle    = rst && (r_state == ST_IDLE);
    assign w_if_prio = if_req && (r_starve_cnt == STARVE_LIM);
    assign w_dm_win  = w_idle && dm_req && !w_if_prio;
    assign w_if_win  = w_idle && if_req && !w_dm_win;
    assign w_last    = (r_lat_cnt == LAT_LAST);

    assign if_gnt = w_if_win;
    assign dm_gnt = w_dm_win;

    // The memory returns data during the final BUSY cycle, so the pulse
    // forwards mem_rdata directly; the register holds it afterwards.
    assign if_valid = (r_state == ST_BUSY_IF) && w_last;
    assign dm_valid = (r_state == ST_BUSY_DM) && w_last;
    assign if_rdata = if_valid ? mem_rdata : r_if_rdata;
    assign dm_rdata = dm_valid ? mem_rdata : r_dm_rdata;

    always_comb begin
        w_sel_addr = 32'd0;
        if (w_dm_win)
            w_sel_addr = dm_addr;
        else if (w_if_win)
            w_sel_addr = if_addr;
    end

    assign mem_en    = w_if_win || w_dm_win;
    assign mem_we    = w_dm_win && dm_we;
    assign mem_addr  = w_sel_addr & 32'hFFFF_FFFC;
    assign mem_be    = w_dm_win ? (dm_we ? w_fmt_be : 4'b1111)
                     : (w_if_win ? 4'b1111 : 4'b0000);
    assign mem_wdata = (w_dm_win && dm_we) ? w_fmt_wdata : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= 4'd0;
            r_lat_cnt    <= 3'd0;
            r_if_rdata   <= 32'd0;
            r_dm_rdata   <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_lat_cnt <= 3'd0;
                    if (w_dm_win)
                        r_state <= ST_BUSY_DM;
                    else if (w_if_win)
                        r_state <= ST_BUSY_IF;
                end
                ST_BUSY_IF, ST_BUSY_DM: begin
                    if (w_last) begin
                        r_state   <= ST_IDLE;
                        r_lat_cnt <= 3'd0;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 3'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (if_valid)
                r_if_rdata <= mem_rdata;
            if (dm_valid)
                r_dm_rdata <= mem_rdata;

            // Starvation counts data grants taken while fetch was waiting
            if (w_if_win)
                r_starve_cnt <= 4'd0;
            else if (w_dm_win && if_req && (r_starve_cnt != STARVE_LIM))
                r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Drives two arbiters (MEM_LAT=1 and MEM_LAT=3, STARVE_MAX=3) with shared
// stimulus. Each has a transaction-level reference model and a fixed-latency
// memory model; directed sequences pin literal expectations.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int STARVE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic        dm_byte;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;

    int tchk = 0;
    int terr = 0;

    always #5 clk = ~clk;

    // Memory contents as seen by reads: a fixed function of the word address
    function automatic logic [31:0] mem_hash(input logic [31:0] a);
        if (a == 32'h0000_0400)
            return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'hA5C3, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int LAT = (g == 0) ? 1 : 3;

        logic        if_gnt, if_valid, dm_gnt, dm_valid, mem_en, mem_we;
        logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
        logic [3:0]  mem_be;

        mem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(STARVE)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_gnt    (if_gnt),
            .if_valid  (if_valid),
            .if_rdata  (if_rdata),
            .dm_req    (dm_req),
            .dm_we     (dm_we),
            .dm_byte   (dm_byte),
            .dm_addr   (dm_addr),
            .dm_wdata  (dm_wdata),
            .dm_gnt    (dm_gnt),
            .dm_valid  (dm_valid),
            .dm_rdata  (dm_rdata),
            .mem_en    (mem_en),
            .mem_we    (mem_we),
            .mem_addr  (mem_addr),
            .mem_be    (mem_be),
            .mem_wdata (mem_wdata),
            .mem_rdata (mem_rdata)
        );

        // Fixed-latency memory: read data appears LAT cycles after mem_en
        logic [LAT-1:0] sr_v = '0;
        logic [31:0]    sr_d [LAT];
        logic [31:0]    junk = 32'd0;
        logic           req_now = 1'b0;
        logic [31:0]    addr_now = 32'd0;

        always @(posedge clk) begin
            for (int i = LAT - 1; i > 0; i--) begin
                sr_v[i] <= sr_v[i-1];
                sr_d[i] <= sr_d[i-1];
            end
            sr_v[0] <= req_now;
            sr_d[0] <= mem_hash(addr_now);
            junk    <= $urandom;
        end
        assign mem_rdata = sr_v[LAT-1] ? sr_d[LAT-1] : junk;

        int chk = 0;
        int err = 0;
        int n = 0;
        int starve = 0;
        int due = 0;
        bit ov = 1'b0;
        bit oport = 1'b0;
        bit ord = 1'b0;
        logic [31:0] oaddr = 32'd0;

        task automatic ck(input string nm, input logic [31:0] act, input logic [31:0] exp);
            chk++;
            if (act !== exp) begin
                err++;
                $display("FAIL %s lat%0d cycle %0d: got %h want %h", nm, LAT, n, act, exp);
            end
        endtask

        // Reference model: one outstanding transaction tracked by due cycle
        initial forever begin
            bit fp, dw, iw;
            logic [3:0]  ebe;
            logic [31:0] ewd;
            @(negedge clk);
            n++;
            req_now  = mem_en && !mem_we && rst;
            addr_now = mem_addr;
            ck("starve_cnt", 32'(u_dut.r_starve_cnt), rst ? 32'(starve) : 32'd0);
            if (!rst) begin
                ck("rst_if_gnt",   32'(if_gnt),   32'd0);
                ck("rst_dm_gnt",   32'(dm_gnt),   32'd0);
                ck("rst_if_valid", 32'(if_valid), 32'd0);
                ck("rst_dm_valid", 32'(dm_valid), 32'd0);
                ck("rst_mem_en",   32'(mem_en),   32'd0);
                ck("rst_mem_we",   32'(mem_we),   32'd0);
                ck("rst_mem_be",   32'(mem_be),   32'd0);
                ck("rst_if_rdata", if_rdata,      32'd0);
                ck("rst_dm_rdata", dm_rdata,      32'd0);
                ov = 1'b0;
                starve = 0;
            end else if (ov) begin
                ck("busy_if_gnt", 32'(if_gnt), 32'd0);
                ck("busy_dm_gnt", 32'(dm_gnt), 32'd0);
                ck("busy_mem_en", 32'(mem_en), 32'd0);
                ck("busy_mem_we", 32'(mem_we), 32'd0);
                ck("if_valid", 32'(if_valid), 32'((n == due) && !oport));
                ck("dm_valid", 32'(dm_valid), 32'((n == due) && oport));
                if (n == due && ord) begin
                    if (oport)
                        ck("dm_rdata", dm_rdata, mem_hash(oaddr));
                    else
                        ck("if_rdata", if_rdata, mem_hash(oaddr));
                end
                if (n == due)
                    ov = 1'b0;
            end else begin
                fp = if_req && (starve == STARVE);
                dw = dm_req && !fp;
                iw = if_req && !dw;
                ck("if_gnt",   32'(if_gnt),   32'(iw));
                ck("dm_gnt",   32'(dm_gnt),   32'(dw));
                ck("mem_en",   32'(mem_en),   32'(dw || iw));
                ck("if_valid", 32'(if_valid), 32'd0);
                ck("dm_valid", 32'(dm_valid), 32'd0);
                if (dw) begin
                    ebe = (dm_we && dm_byte) ? (4'b0001 << dm_addr[1:0]) : 4'b1111;
                    ewd = dm_byte ? {4{dm_wdata[7:0]}} : dm_wdata;
                    ck("dm_mem_addr", mem_addr, dm_addr & 32'hFFFF_FFFC);
                    ck("dm_mem_we",   32'(mem_we), 32'(dm_we));
                    ck("dm_mem_be",   32'(mem_be), 32'(ebe));
                    if (dm_we)
                        ck("dm_mem_wdata", mem_wdata, ewd);
                    ov = 1'b1; oport = 1'b1; ord = !dm_we;
                    oaddr = dm_addr & 32'hFFFF_FFFC;
                    due = n + LAT;
                    if (if_req && starve < STARVE)
                        starve++;
                end else if (iw) begin
                    ck("if_mem_addr", mem_addr, if_addr & 32'hFFFF_FFFC);
                    ck("if_mem_we",   32'(mem_we), 32'd0);
                    ck("if_mem_be",   32'(mem_be), 32'hF);
                    ov = 1'b1; oport = 1'b0; ord = 1'b1;
                    oaddr = if_addr & 32'hFFFF_FFFC;
                    due = n + LAT;
                    starve = 0;
                end else begin
                    ck("idle_mem_we", 32'(mem_we), 32'd0);
                end
            end
        end
    end

    task automatic dck(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tchk++;
        if (act !== exp) begin
            terr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 1'b0; if_addr = 32'd0;
        dm_req = 1'b0; dm_we = 1'b0; dm_byte = 1'b0;
        dm_addr = 32'd0; dm_wdata = 32'd0;
    endtask

    task automatic do_reset();
        next();
        clear_inputs();
        rst = 1'b0;
        next();
        rst = 1'b1;
    endtask

    initial begin
        int ndm, lat, seen;
        bit got;
        rst = 1'b0;
        clear_inputs();
        repeat (2) next();
        rst = 1'b1;

        // Simultaneous requests, MEM_LAT=1
        do_reset();
        if_req = 1'b1; if_addr = 32'h100; dm_req = 1'b1; dm_addr = 32'h200;
        @(negedge clk);
        dck("t40_dm_gnt", 32'(cfg[0].dm_gnt), 32'd1);
        dck("t40_if_gnt_blocked", 32'(cfg[0].if_gnt), 32'd0);
        next();
        dm_req = 1'b0;
        @(negedge clk);
        dck("t40_dm_valid", 32'(cfg[0].dm_valid), 32'd1);
        next();
        @(negedge clk);
        dck("t40_if_gnt", 32'(cfg[0].if_gnt), 32'd1);
        next();
        if_req = 1'b0;

        // Starvation limit, MEM_LAT=1
        do_reset();
        if_req = 1'b1; if_addr = 32'h300; dm_req = 1'b1; dm_addr = 32'h500;
        ndm = 0; got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (cfg[0].dm_gnt) ndm++;
            if (cfg[0].if_gnt) got = 1'b1;
            next();
        end
        dck("t41_if_gnt_seen", 32'(got), 32'd1);
        dck("t41_dm_gnt_count", 32'(ndm), 32'd3);
        @(negedge clk);
        dck("t41_starve_clear", 32'(cfg[0].u_dut.r_starve_cnt), 32'd0);
        next();
        clear_inputs();

        // Byte store formatting
        do_reset();
        dm_req = 1'b1; dm_we = 1'b1; dm_byte = 1'b1;
        dm_addr = 32'h1006; dm_wdata = 32'h0000_00AB;
        @(negedge clk);
        dck("t42_mem_be",    32'(cfg[0].mem_be), 32'h4);
        dck("t42_mem_wdata", cfg[0].mem_wdata,   32'hABAB_ABAB);
        dck("t42_mem_addr",  cfg[0].mem_addr,    32'h1004);
        dck("t42_mem_we",    32'(cfg[0].mem_we), 32'd1);
        next();
        clear_inputs();

        // Latency, MEM_LAT=3
        do_reset();
        if_req = 1'b1; if_addr = 32'h400;
        @(negedge clk);
        dck("t43_if_gnt", 32'(cfg[1].if_gnt), 32'd1);
        next();
        if_req = 1'b0;
        lat = 0; seen = 0;
        for (int k = 1; k <= 10 && seen == 0; k++) begin
            @(negedge clk);
            if (cfg[1].if_valid) begin
                seen = 1;
                lat = k;
                dck("t43_if_rdata", cfg[1].if_rdata, 32'hDEAD_BEEF);
            end
            next();
        end
        dck("t43_valid_seen", 32'(seen), 32'd1);
        dck("t43_latency", 32'(lat), 32'd3);

        // Reset during BUSY_DM
        do_reset();
        dm_req = 1'b1; dm_addr = 32'h80;
        @(negedge clk);
        dck("t44_dm_gnt", 32'(cfg[0].dm_gnt), 32'd1);
        next();
        dm_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        dck("t44_dm_valid",  32'(cfg[0].dm_valid), 32'd0);
        dck("t44_state",     32'(cfg[0].u_dut.r_state), 32'(ST_IDLE));
        dck("t44_mem_en",    32'(cfg[0].mem_en), 32'd0);
        dck("t44_mem_be",    32'(cfg[0].mem_be), 32'd0);
        dck("t44_dm_rdata",  cfg[0].dm_rdata, 32'd0);
        next();
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (cfg[0].dm_valid || cfg[1].dm_valid) seen++;
            next();
        end
        dck("t44_no_late_valid", 32'(seen), 32'd0);
        dck("t44_state_lat3", 32'(cfg[1].u_dut.r_state), 32'(ST_IDLE));

        // Continuous fetch throughput, MEM_LAT=1
        do_reset();
        if_req = 1'b1; if_addr = 32'h40;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            dck("t45_if_gnt", 32'(cfg[0].if_gnt), 32'((k % 2) == 0));
            dck("t45_mem_we", 32'(cfg[0].mem_we), 32'd0);
            next();
            if_addr = if_addr + 32'd4;
        end
        clear_inputs();

        // Randomized traffic checked by the per-instance models
        for (int k = 0; k < 3000; k++) begin
            rst      = ($urandom_range(0, 249) != 0);
            if_req   = ($urandom_range(0, 3) != 0);
            dm_req   = ($urandom_range(0, 2) != 0);
            dm_we    = $urandom_range(0, 1) == 1;
            dm_byte  = $urandom_range(0, 1) == 1;
            if_addr  = $urandom;
            dm_addr  = $urandom;
            dm_wdata = $urandom;
            next();
        end
        rst = 1'b1;
        clear_inputs();
        repeat (6) next();

        $display("CHECKS %0d ERRORS %0d",
                 tchk + cfg[0].chk + cfg[1].chk,
                 terr + cfg[0].err + cfg[1].err);
        $finish;
    end

endmodule
